// File: rtl/cascade_vote_n.sv
// rtl/cascade_vote_n.sv - N-stage weighted-vote classifier cascade controller
// Sequences classifiers one at a time, accumulates a signed score, early-rejects and times out stalled stages.
module cascade_vote_n #(
    parameter int                        N_STAGES      = 3,
    parameter int                        ADDR_W        = 15,
    parameter int                        SCORE_W       = 8,
    parameter logic [N_STAGES*4-1:0]     STAGE_WEIGHTS = {4'd1, 4'd1, 4'd1},
    parameter int                        THRESH        = 0,
    parameter int                        EARLY_REJECT  = 1,
    parameter int                        TIMEOUT       = 1023
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         detect_en,
    input  logic                         abort,
    output logic                         detect_done,
    output logic                         detected_flag,
    output logic signed [SCORE_W-1:0]    score,
    output logic                         timeout_flag,
    output logic [4:0]                   stages_run,
    output logic [N_STAGES-1:0]          stage_en,
    input  logic [N_STAGES-1:0]          stage_done,
    input  logic [N_STAGES-1:0]          stage_flag,
    input  logic [N_STAGES*ADDR_W-1:0]   stage_addr,
    output logic [ADDR_W-1:0]            rd_addr
);

    localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_FINISH
    } state_t;

    state_t                     state_q;
    logic [IDX_W-1:0]           idx_q;
    logic signed [SCORE_W-1:0]  acc_q;
    logic signed [SCORE_W-1:0]  acc_d;
    logic [31:0]                wd_q;
    logic                       detect_en_z_q;
    logic                       armed_q;
    logic                       detect_done_q;
    logic                       detected_flag_q;
    logic signed [SCORE_W-1:0]  score_q;
    logic                       timeout_flag_q;
    logic [4:0]                 stages_run_q;
    logic [N_STAGES-1:0]        stage_en_q;

    logic [3:0]                 w_sel;
    logic signed [SCORE_W-1:0]  w_s;
    logic                       done_sel;
    logic                       flag_sel;
    logic [ADDR_W-1:0]          addr_sel;
    int                         rem_w;
    logic                       timeout_hit;
    logic                       vote;
    logic                       last_stage;
    logic                       reject;
    logic                       start;

    // armed_q blocks a level that was already high when reset released from counting as an edge
    assign start = detect_en && !detect_en_z_q && armed_q;

    always_comb begin
        w_sel    = '0;
        done_sel = 1'b0;
        flag_sel = 1'b0;
        addr_sel = '0;
        rem_w    = 0;
        for (int i = 0; i < N_STAGES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                w_sel    = STAGE_WEIGHTS[i*4 +: 4];
                done_sel = stage_done[i];
                flag_sel = stage_flag[i];
                addr_sel = stage_addr[i*ADDR_W +: ADDR_W];
            end
            if (i > int'(idx_q)) begin
                rem_w = rem_w + int'(STAGE_WEIGHTS[i*4 +: 4]);
            end
        end
        w_s         = $signed(SCORE_W'(w_sel));
        timeout_hit = (TIMEOUT != 0) && (wd_q == 32'(TIMEOUT - 1));
        // a real done on the watchdog cycle wins, so only count the flag when done is present
        acc_d       = acc_q + ((done_sel && flag_sel) ? w_s : -w_s);
        vote        = done_sel || timeout_hit;
        last_stage  = (idx_q == IDX_W'(N_STAGES - 1));
        reject      = (EARLY_REJECT != 0) && ((int'(acc_d) + rem_w) < THRESH);
        rd_addr     = (state_q == S_RUN) ? addr_sel : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            idx_q           <= '0;
            acc_q           <= '0;
            wd_q            <= '0;
            detect_en_z_q   <= 1'b0;
            armed_q         <= 1'b0;
            detect_done_q   <= 1'b0;
            detected_flag_q <= 1'b0;
            score_q         <= '0;
            timeout_flag_q  <= 1'b0;
            stages_run_q    <= '0;
            stage_en_q      <= '0;
        end else begin
            detect_en_z_q <= detect_en;
            if (!detect_en) begin
                armed_q <= 1'b1;
            end
            detect_done_q <= 1'b0;
            if (abort) begin
                state_q    <= S_IDLE;
                stage_en_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q        <= S_RUN;
                            idx_q          <= '0;
                            acc_q          <= '0;
                            wd_q           <= '0;
                            timeout_flag_q <= 1'b0;
                            stage_en_q     <= N_STAGES'(1);
                        end
                    end
                    S_RUN: begin
                        if (vote) begin
                            acc_q      <= acc_d;
                            stage_en_q <= '0;
                            if (!done_sel) begin
                                timeout_flag_q <= 1'b1;
                            end
                            state_q <= (last_stage || reject) ? S_FINISH : S_GAP;
                        end else begin
                            wd_q <= wd_q + 32'd1;
                        end
                    end
                    S_GAP: begin
                        state_q    <= S_RUN;
                        idx_q      <= idx_q + IDX_W'(1);
                        wd_q       <= '0;
                        stage_en_q <= N_STAGES'(1) << (int'(idx_q) + 1);
                    end
                    S_FINISH: begin
                        detected_flag_q <= (int'(acc_q) >= THRESH);
                        score_q         <= acc_q;
                        stages_run_q    <= 5'(idx_q) + 5'd1;
                        detect_done_q   <= 1'b1;
                        state_q         <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign detect_done   = detect_done_q;
    assign detected_flag = detected_flag_q;
    assign score         = score_q;
    assign timeout_flag  = timeout_flag_q;
    assign stages_run    = stages_run_q;
    assign stage_en      = stage_en_q;

endmodule

// File: tb/tb_cascade_vote_n.sv
// tb/tb_cascade_vote_n.sv - directed scoreboard bench for cascade_vote_n
module tb_cascade_vote_n;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    int                 cyc = 0;
    int                 checks = 0;
    int                 failures = 0;
    int                 done_cnt = 0;
    logic               en2_seen = 1'b0;

    logic               det_a = 1'b0, abort_a = 1'b0;
    logic [2:0]         sdone_a = '0, sflag_a = '0;
    logic [44:0]        saddr_a = {15'h3003, 15'h2002, 15'h1001};
    logic               done_a, flag_a, tflag_a;
    logic signed [7:0]  score_a;
    logic [4:0]         run_a;
    logic [2:0]         en_a;
    logic [14:0]        rd_a;

    logic               det_b = 1'b0, abort_b = 1'b0;
    logic [2:0]         sdone_b = '0, sflag_b = '0;
    logic [44:0]        saddr_b = '0;
    logic               done_b, flag_b, tflag_b;
    logic signed [7:0]  score_b;
    logic [4:0]         run_b;
    logic [2:0]         en_b;
    logic [14:0]        rd_b;

    typedef struct {
        logic flag;
        int   score;
        int   run;
        logic tflag;
        int   done_cyc;
    } exp_t;
    exp_t q[$];

    cascade_vote_n #(.N_STAGES(3), .ADDR_W(15), .SCORE_W(8),
                     .STAGE_WEIGHTS({4'd1, 4'd1, 4'd1}), .THRESH(0),
                     .EARLY_REJECT(1), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst), .detect_en(det_a), .abort(abort_a),
        .detect_done(done_a), .detected_flag(flag_a), .score(score_a),
        .timeout_flag(tflag_a), .stages_run(run_a), .stage_en(en_a),
        .stage_done(sdone_a), .stage_flag(sflag_a), .stage_addr(saddr_a),
        .rd_addr(rd_a)
    );

    cascade_vote_n #(.N_STAGES(3), .ADDR_W(15), .SCORE_W(8),
                     .STAGE_WEIGHTS({4'd1, 4'd1, 4'd3}), .THRESH(1),
                     .EARLY_REJECT(1), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst), .detect_en(det_b), .abort(abort_b),
        .detect_done(done_b), .detected_flag(flag_b), .score(score_b),
        .timeout_flag(tflag_b), .stages_run(run_b), .stage_en(en_b),
        .stage_done(sdone_b), .stage_flag(sflag_b), .stage_addr(saddr_b),
        .rd_addr(rd_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (en_a[2]) en2_seen = 1'b1;
        if (done_a) begin
            exp_t e;
            done_cnt++;
            check("done_expected", (q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("detected_flag", flag_a, e.flag);
                check("score", score_a, e.score);
                check("stages_run", run_a, e.run);
                check("timeout_flag", tflag_a, e.tflag);
                if (e.done_cyc >= 0) check("latency", cyc, e.done_cyc);
            end
        end
    end

    // k = stages expected to run with zero-latency classifiers, -1 skips the latency check
    task automatic start_a(input bit push, input logic f, input int s, input int r, input logic t, input int k);
        exp_t e;
        @(posedge clk); #1;
        det_a = 1'b1;
        if (push) begin
            e.flag = f; e.score = s; e.run = r; e.tflag = t;
            e.done_cyc = (k >= 0) ? cyc + 1 + 2 * k : -1;
            q.push_back(e);
        end
        @(posedge clk); #1;
        det_a = 1'b0;
    endtask

    task automatic run_stage(input bit b, input int i, input logic f);
        int n = 0;
        logic [2:0] want;
        want = 3'(1 << i);
        do begin
            @(negedge clk);
            n++;
        end while (((b ? en_b : en_a) != want) && n < 40);
        check($sformatf("stage_en_%0d", i), b ? en_b : en_a, want);
        if (!b) check($sformatf("rd_addr_%0d", i), rd_a, saddr_a[i*15 +: 15]);
        if (b) begin
            sdone_b[i] = 1'b1; sflag_b[i] = f;
        end else begin
            sdone_a[i] = 1'b1; sflag_a[i] = f;
        end
        @(posedge clk); #1;
        sdone_a = '0; sdone_b = '0;
    endtask

    task automatic drain;
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", q.size(), 0);
    endtask

    initial begin
        int n;
        int cnt;
        int dc;
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        int cnt;
        int dc;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stage_en", en_a, 0);
        check("rst_done", done_a, 0);
        check("rst_score", score_a, 0);
        check("rst_stages_run", run_a, 0);
        check("rst_rd_addr", rd_a, 0);
        rst = 1'b0;

        // all three stages, flags 1,0,1
        start_a(1, 1'b1, 1, 3, 1'b0, 3);
        run_stage(0, 0, 1'b1);
        run_stage(0, 1, 1'b0);
        run_stage(0, 2, 1'b1);
        drain();

        // early rejection after two negative votes
        en2_seen = 1'b0;
        start_a(1, 1'b0, -2, 2, 1'b0, 2);
        run_stage(0, 0, 1'b0);
        run_stage(0, 1, 1'b0);
        drain();
        check("en2_never_set", en2_seen, 0);

        // stage 1 stalls until the watchdog fires
        start_a(1, 1'b1, 1, 3, 1'b1, -1);
        run_stage(0, 0, 1'b1);
        n = 0;
        cnt = 0;
        while (en_a != 3'b010 && n < 20) begin
            @(negedge clk); n++;
        end
        while (en_a == 3'b010 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check("timeout_en_cycles", cnt, 8);
        check("timeout_flag_live", tflag_a, 1);
        run_stage(0, 2, 1'b1);
        drain();

        // abort in stage 1 on the same cycle as its done pulse
        dc = done_cnt;
        start_a(0, 1'b0, 0, 0, 1'b0, -1);
        run_stage(0, 0, 1'b0);
        n = 0;
        while (en_a != 3'b010 && n < 20) begin
            @(negedge clk); n++;
        end
        abort_a = 1'b1;
        sdone_a[1] = 1'b1;
        sflag_a[1] = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        sdone_a = '0;
        check("abort_stage_en", en_a, 0);
        repeat (6) @(negedge clk);
        check("abort_no_done", done_cnt, dc);
        check("abort_en_idle", en_a, 0);
        check("abort_score_kept", score_a, 1);
        check("abort_flag_kept", flag_a, 1);
        check("abort_run_kept", run_a, 3);
        start_a(1, 1'b1, 3, 3, 1'b0, 3);
        run_stage(0, 0, 1'b1);
        run_stage(0, 1, 1'b1);
        run_stage(0, 2, 1'b1);
        drain();

        // asynchronous reset in the middle of stage 1
        start_a(0, 1'b0, 0, 0, 1'b0, -1);
        det_a = 1'b1;
        run_stage(0, 0, 1'b1);
        n = 0;
        while (en_a != 3'b010 && n < 20) begin
            @(negedge clk); n++;
        end
        #2 rst = 1'b1;
        #1;
        check("arst_stage_en", en_a, 0);
        check("arst_score", score_a, 0);
        check("arst_flag", flag_a, 0);
        check("arst_stages_run", run_a, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        dc = done_cnt;
        repeat (6) @(negedge clk);
        check("held_level_no_start", en_a, 0);
        check("held_level_no_done", done_cnt, dc);
        det_a = 1'b0;
        start_a(1, 1'b0, -1, 3, 1'b0, 3);
        run_stage(0, 0, 1'b0);
        run_stage(0, 1, 1'b1);
        run_stage(0, 2, 1'b0);
        drain();

        // weighted instance: W=3,1,1, THRESH=1
        @(posedge clk); #1;
        det_b = 1'b1;
        @(posedge clk); #1;
        det_b = 1'b0;
        run_stage(1, 0, 1'b1);
        run_stage(1, 1, 1'b0);
        run_stage(1, 2, 1'b0);
        n = 0;
        while (!done_b && n < 20) begin
            @(negedge clk); n++;
        end
        check("w_done_seen", done_b, 1);
        check("w_score", score_b, 1);
        check("w_flag", flag_b, 1);
        check("w_stages_run", run_b, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
